// File: rtl/button_switch_conditioner.sv
// Synchronises and debounces a push-button and a 3-bit slide switch.
// Produces press, long-press and switch-change strobes plus clean levels.
module button_switch_conditioner #(
  parameter logic [31:0] DEBOUNCE_CYCLES   = 32'd1_000_000,
  parameter logic [31:0] LONG_PRESS_CYCLES = 32'd100_000_000,
  parameter int          SYNC_STAGES       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button_raw,
  input  logic [2:0] switch_raw,
  output logic       btn_pulse,
  output logic       btn_level,
  output logic       long_pulse,
  output logic [2:0] switch_out,
  output logic       switch_changed
);

  localparam logic [31:0] DEB_LAST  = DEBOUNCE_CYCLES - 32'd1;
  localparam logic [31:0] LONG_LAST = LONG_PRESS_CYCLES - 32'd1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  logic [SYNC_STAGES-1:0]      btn_sync_q, btn_sync_d;
  logic [SYNC_STAGES-1:0][2:0] sw_sync_q, sw_sync_d;
  logic                        btn_s;
  logic [2:0]                  sw_s;

  btn_state_e  state_q, state_d;
  logic [31:0] deb_cnt_q, deb_cnt_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic        press_evt_q, press_evt_d;
  logic        long_evt_q, long_evt_d;
  logic        btn_pulse_q, btn_pulse_d;
  logic        btn_level_q, btn_level_d;
  logic        long_pulse_q, long_pulse_d;

  logic [2:0]  sw_cand_q, sw_cand_d;
  logic [31:0] sw_cnt_q, sw_cnt_d;
  logic [2:0]  switch_out_q, switch_out_d;
  logic        switch_changed_q, switch_changed_d;

  always_comb begin
    btn_sync_d = {btn_sync_q[SYNC_STAGES-2:0], button_raw};
    sw_sync_d  = {sw_sync_q[SYNC_STAGES-2:0], switch_raw};
  end

  assign btn_s = btn_sync_q[SYNC_STAGES-1];
  assign sw_s  = sw_sync_q[SYNC_STAGES-1];

  // Button FSM: deb_cnt counts agreeing samples, hold_cnt freezes during RELEASE_WAIT.
  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    press_evt_d = 1'b0;
    long_evt_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d   = PRESS_WAIT;
          deb_cnt_d = 32'd1;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d   = IDLE;
          deb_cnt_d = 32'd0;
        end else if (deb_cnt_q >= DEB_LAST) begin
          state_d     = PRESSED;
          press_evt_d = 1'b1;
          hold_cnt_d  = 32'd0;
        end else begin
          deb_cnt_d = deb_cnt_q + 32'd1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d   = RELEASE_WAIT;
          deb_cnt_d = 32'd1;
        end else begin
          if (hold_cnt_q < LONG_PRESS_CYCLES) hold_cnt_d = hold_cnt_q + 32'd1;
          if (hold_cnt_q == LONG_LAST) long_evt_d = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = PRESSED;
        end else if (deb_cnt_q >= DEB_LAST) begin
          state_d   = IDLE;
          deb_cnt_d = 32'd0;
        end else begin
          deb_cnt_d = deb_cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Events pass through one more register so press and release both land
  // SYNC_STAGES+DEBOUNCE_CYCLES clocks after the first sampling edge.
  always_comb begin
    btn_pulse_d  = press_evt_q;
    long_pulse_d = long_evt_q;
    btn_level_d  = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
  end

  // Any bit change reloads the candidate, so multi-bit moves commit together.
  always_comb begin
    sw_cand_d        = sw_cand_q;
    sw_cnt_d         = sw_cnt_q;
    switch_out_d     = switch_out_q;
    switch_changed_d = 1'b0;
    if (sw_s != sw_cand_q) begin
      sw_cand_d = sw_s;
      sw_cnt_d  = 32'd0;
    end else if (sw_cand_q != switch_out_q) begin
      if (sw_cnt_q >= DEB_LAST) begin
        switch_out_d     = sw_cand_q;
        switch_changed_d = 1'b1;
        sw_cnt_d         = 32'd0;
      end else begin
        sw_cnt_d = sw_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync_q       <= '0;
      sw_sync_q        <= '0;
      state_q          <= IDLE;
      deb_cnt_q        <= 32'd0;
      hold_cnt_q       <= 32'd0;
      press_evt_q      <= 1'b0;
      long_evt_q       <= 1'b0;
      btn_pulse_q      <= 1'b0;
      btn_level_q      <= 1'b0;
      long_pulse_q     <= 1'b0;
      sw_cand_q        <= 3'b000;
      sw_cnt_q         <= 32'd0;
      switch_out_q     <= 3'b000;
      switch_changed_q <= 1'b0;
    end else begin
      btn_sync_q       <= btn_sync_d;
      sw_sync_q        <= sw_sync_d;
      state_q          <= state_d;
      deb_cnt_q        <= deb_cnt_d;
      hold_cnt_q       <= hold_cnt_d;
      press_evt_q      <= press_evt_d;
      long_evt_q       <= long_evt_d;
      btn_pulse_q      <= btn_pulse_d;
      btn_level_q      <= btn_level_d;
      long_pulse_q     <= long_pulse_d;
      sw_cand_q        <= sw_cand_d;
      sw_cnt_q         <= sw_cnt_d;
      switch_out_q     <= switch_out_d;
      switch_changed_q <= switch_changed_d;
    end
  end

  assign btn_pulse      = btn_pulse_q;
  assign btn_level      = btn_level_q;
  assign long_pulse     = long_pulse_q;
  assign switch_out     = switch_out_q;
  assign switch_changed = switch_changed_q;

endmodule

// File: tb/tb_button_switch_conditioner.sv
// Bench for button_switch_conditioner: directed scenarios plus random bounce,
// every cycle compared against a sample-window reference model.
module tb_button_switch_conditioner;

  localparam int DEB  = 4;
  localparam int LONG = 16;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       button_raw;
  logic [2:0] switch_raw;
  logic       btn_pulse, btn_level, long_pulse, switch_changed;
  logic [2:0] switch_out;

  always #5 clk = ~clk;

  button_switch_conditioner #(
    .DEBOUNCE_CYCLES  (32'd4),
    .LONG_PRESS_CYCLES(32'd16),
    .SYNC_STAGES      (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .button_raw    (button_raw),
    .switch_raw    (switch_raw),
    .btn_pulse     (btn_pulse),
    .btn_level     (btn_level),
    .long_pulse    (long_pulse),
    .switch_out    (switch_out),
    .switch_changed(switch_changed)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a level flips once the last DEB synchronised samples all
  // disagree with it; the switch commits after DEB+1 identical samples.
  bit       b_pipe[$];
  bit [2:0] sw_pipe[$];
  bit       b_win[$];
  bit [2:0] sw_win[$];
  bit       m_level, m_prev_seen, m_press_pend, m_long_pend;
  int       m_held;
  bit [2:0] m_sw;
  bit       exp_pulse, exp_level, exp_long, exp_chg;
  bit [2:0] exp_sw;

  task automatic model_reset();
    b_pipe = {};
    sw_pipe = {};
    for (int i = 0; i < SYNC; i++) begin
      b_pipe.push_back(1'b0);
      sw_pipe.push_back(3'b000);
    end
    b_win = {};
    sw_win = {};
    m_level = 0; m_prev_seen = 0; m_press_pend = 0; m_long_pend = 0;
    m_held = 0; m_sw = 3'b000;
    exp_pulse = 0; exp_level = 0; exp_long = 0; exp_chg = 0; exp_sw = 3'b000;
  endtask

  task automatic model_step(input bit b, input bit [2:0] sw);
    bit       seen;
    bit [2:0] sw_seen;
    bit       all_opp, all_eq;
    exp_pulse = m_press_pend;
    exp_long  = m_long_pend;
    exp_level = m_level;
    seen = b_pipe.pop_front();
    b_pipe.push_back(b);
    b_win.push_back(seen);
    if (b_win.size() > DEB) void'(b_win.pop_front());
    m_press_pend = 0;
    m_long_pend  = 0;
    if (m_level && m_prev_seen && seen) begin
      m_held++;
      if (m_held == LONG) m_long_pend = 1;
    end
    if (b_win.size() == DEB) begin
      all_opp = 1;
      foreach (b_win[i]) if (b_win[i] == m_level) all_opp = 0;
      if (all_opp) begin
        m_level = !m_level;
        if (m_level) begin
          m_press_pend = 1;
          m_held = 0;
        end
      end
    end
    m_prev_seen = seen;

    sw_seen = sw_pipe.pop_front();
    sw_pipe.push_back(sw);
    sw_win.push_back(sw_seen);
    if (sw_win.size() > DEB + 1) void'(sw_win.pop_front());
    exp_chg = 0;
    if (sw_win.size() == DEB + 1) begin
      all_eq = 1;
      foreach (sw_win[i]) if (sw_win[i] != sw_win[0]) all_eq = 0;
      if (all_eq && sw_win[0] != m_sw) begin
        m_sw = sw_win[0];
        exp_chg = 1;
      end
    end
    exp_sw = m_sw;
  endtask

  int tcount = 0;
  int n_pulse, n_long, n_chg;
  int pulse_t, long_t, chg_t;

  task automatic clear_stats();
    n_pulse = 0; n_long = 0; n_chg = 0;
    pulse_t = -1; long_t = -1; chg_t = -1;
  endtask

  // One clock: drive after the falling edge, model at the rising edge, compare at the next falling edge.
  task automatic tick(input bit b, input bit [2:0] sw);
    button_raw = b;
    switch_raw = sw;
    @(posedge clk);
    model_step(b, sw);
    @(negedge clk);
    check_eq("btn_pulse", btn_pulse, exp_pulse);
    check_eq("btn_level", btn_level, exp_level);
    check_eq("long_pulse", long_pulse, exp_long);
    check_eq("switch_out", switch_out, exp_sw);
    check_eq("switch_changed", switch_changed, exp_chg);
    check_eq("pulse_long_overlap", btn_pulse & long_pulse, 0);
    if (btn_pulse) begin n_pulse++; if (pulse_t < 0) pulse_t = tcount; end
    if (long_pulse) begin n_long++; if (long_t < 0) long_t = tcount; end
    if (switch_changed) begin n_chg++; if (chg_t < 0) chg_t = tcount; end
    tcount++;
  endtask

  task automatic hold(input bit b, input bit [2:0] sw, input int n);
    for (int i = 0; i < n; i++) tick(b, sw);
  endtask

  task automatic apply_reset(input bit b, input bit [2:0] sw);
    button_raw = b;
    switch_raw = sw;
    rst_n = 1'b0;
    #1;
    check_eq("rst_btn_pulse", btn_pulse, 0);
    check_eq("rst_btn_level", btn_level, 0);
    check_eq("rst_long_pulse", long_pulse, 0);
    check_eq("rst_switch_out", switch_out, 0);
    check_eq("rst_switch_changed", switch_changed, 0);
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int base, b_left, s_left;
  bit rb;
  bit [2:0] rsw;

  initial begin
    rst_n = 1'b0;
    button_raw = 1'b0;
    switch_raw = 3'b000;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    apply_reset(1'b0, 3'b000);

    // Clean press: strobe 6 clocks after the first sampling edge.
    clear_stats(); base = tcount;
    hold(1'b1, 3'b000, 10);
    check_eq("clean_pulse_count", n_pulse, 1);
    check_eq("clean_pulse_delay", pulse_t - base, 6);
    check_eq("clean_level", btn_level, 1);
    hold(1'b0, 3'b000, 10);
    check_eq("clean_release_level", btn_level, 0);

    // Bounce never accepted.
    clear_stats();
    tick(1'b1, 3'b000); tick(1'b0, 3'b000); tick(1'b1, 3'b000); tick(1'b0, 3'b000);
    hold(1'b0, 3'b000, 10);
    check_eq("bounce_pulse_count", n_pulse, 0);
    check_eq("bounce_level", btn_level, 0);

    // Long press: one long strobe, 16 clocks after the press strobe.
    clear_stats();
    hold(1'b1, 3'b000, 30);
    check_eq("long_pulse_count", n_pulse, 1);
    check_eq("long_long_count", n_long, 1);
    check_eq("long_delay", long_t - pulse_t, 16);
    hold(1'b0, 3'b000, 10);

    // Release glitch while pressed keeps the level and gives no second press.
    clear_stats();
    hold(1'b1, 3'b000, 10);
    hold(1'b0, 3'b000, 2);
    hold(1'b1, 3'b000, 10);
    check_eq("glitch_pulse_count", n_pulse, 1);
    check_eq("glitch_level", btn_level, 1);
    hold(1'b0, 3'b000, 10);

    // Switch update and a short glitch that must not commit.
    clear_stats(); base = tcount;
    hold(1'b0, 3'b101, 8);
    check_eq("sw_change_count", n_chg, 1);
    check_eq("sw_change_delay", chg_t - base, 6);
    check_eq("sw_value", switch_out, 3'b101);
    clear_stats();
    hold(1'b0, 3'b111, 2);
    hold(1'b0, 3'b101, 8);
    check_eq("sw_glitch_count", n_chg, 0);
    check_eq("sw_glitch_value", switch_out, 3'b101);

    // Reset mid PRESS_WAIT, then mid PRESSED; the held button is re-detected.
    hold(1'b1, 3'b101, 3);
    apply_reset(1'b1, 3'b101);
    clear_stats(); base = tcount;
    hold(1'b1, 3'b101, 10);
    check_eq("post_rst_pulse_count", n_pulse, 1);
    check_eq("post_rst_pulse_delay", pulse_t - base, 6);
    check_eq("post_rst_sw_count", n_chg, 1);
    apply_reset(1'b1, 3'b000);
    clear_stats(); base = tcount;
    hold(1'b1, 3'b000, 10);
    check_eq("rst2_pulse_delay", pulse_t - base, 6);
    hold(1'b0, 3'b000, 10);

    // Random bouncy segments on both inputs.
    b_left = 0; s_left = 0; rb = 0; rsw = 3'b000;
    for (int i = 0; i < 1500; i++) begin
      if (b_left == 0) begin
        rb = 1'($urandom_range(0, 1));
        b_left = (($urandom_range(0, 3)) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(1, 6));
      end
      if (s_left == 0) begin
        rsw = 3'($urandom_range(0, 7));
        s_left = int'($urandom_range(1, 12));
      end
      tick(rb, rsw);
      b_left--;
      s_left--;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
